// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate L1 data cache.
// Load hits answer combinationally; misses stall for a line fill.
module data_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_response,
  output logic              wr_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t state, state_n;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [DATA_W-1:0] lines [SETS][LINE_WORDS];
  logic [DATA_W-1:0] lbuf  [LINE_WORDS];
  logic [OFF_W-1:0]  cnt;

  logic [TAG_W-1:0] req_tag, mtag;
  logic [IDX_W-1:0] req_idx, midx;
  logic [OFF_W-1:0] req_off, moff;
  logic             hit, mhit, last;
  logic             unused;

  assign req_tag = addr[ADDR_W-1 -: TAG_W];
  assign req_idx = addr[2+OFF_W +: IDX_W];
  assign req_off = addr[2 +: OFF_W];

  // The registered memory address carries the tag/index of the
  // operation in flight, so no separate base register is kept.
  assign mtag = mem_addr[ADDR_W-1 -: TAG_W];
  assign midx = mem_addr[2+OFF_W +: IDX_W];
  assign moff = mem_addr[2 +: OFF_W];

  assign hit  = valid[req_idx] && (tags[req_idx] == req_tag);
  assign mhit = valid[midx] && (tags[midx] == mtag);
  assign last = (cnt == OFF_W'(LINE_WORDS - 1));

  assign unused = ^{addr[1:0]};

  assign busy       = (state != IDLE);
  assign data_ready = !reset && (state == IDLE) && rd_req && !wr_req && hit;
  assign data_response = data_ready ? lines[req_idx][req_off] : '0;
  assign wr_done    = !reset && (state == WRITE) && mem_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (wr_req) state_n = WRITE;
        else if (rd_req && !hit) state_n = FILL;
      end
      FILL:    if (mem_ready && last) state_n = IDLE;
      WRITE:   if (mem_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata;
          end else if (rd_req && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            cnt      <= '0;
            mem_addr <= {addr[ADDR_W-1:2+OFF_W], {(OFF_W+2){1'b0}}};
          end
        end
        FILL: begin
          if (mem_ready) begin
            if (last) begin
              mem_req     <= 1'b0;
              cnt         <= '0;
              valid[midx] <= 1'b1;
              tags[midx]  <= mtag;
              for (int w = 0; w < LINE_WORDS - 1; w++)
                lines[midx][w[OFF_W-1:0]] <= lbuf[w[OFF_W-1:0]];
              lines[midx][cnt] <= mem_rdata;
            end else begin
              lbuf[cnt] <= mem_rdata;
              cnt       <= cnt + OFF_W'(1);
              mem_addr  <= mem_addr + ADDR_W'(4);
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mhit) lines[midx][moff] <= mem_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a scoreboard of load results
// and a word-addressed backing-memory model (default data = address).
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset, rd_req, wr_req;
  logic [31:0] addr, wdata;
  logic        data_ready, wr_done, busy;
  logic [31:0] data_response;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem_m [logic [31:0]];

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
    .addr(addr), .wdata(wdata), .data_ready(data_ready),
    .data_response(data_response), .wr_done(wr_done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : a;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv,
                     input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Load: lat is the cycle (0 = request cycle) data_ready must rise.
  task automatic rd(input logic [31:0] a, input int period,
                    input int lat, input string tag);
    logic [31:0] base, e;
    int words;
    bit got;
    exp_q.push_back(model(a));
    base  = {a[31:4], 4'h0};
    words = 0;
    got   = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      rd_req    = 1'b1;
      wr_req    = 1'b0;
      addr      = a;
      mem_ready = (k > 0) && (k % period == 0);
      mem_rdata = model(mem_addr);
      #1;
      if (k == 0) chk(32'(mem_req), 0, {tag, " req0"});
      if (mem_req) begin
        chk(32'(mem_we), 0, {tag, " fill we"});
        chk(mem_addr, base + 32'(4 * words), {tag, " fill addr"});
        if (mem_ready) words++;
      end
      if (data_ready) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk(32'(k), 32'(lat), {tag, " latency"});
        chk(data_response, e, {tag, " data"});
      end
    end
    chk(32'(got), 1, {tag, " timeout"});
    chk(32'(words), (lat > 0) ? 32'd4 : 32'd0, {tag, " words"});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input int stall, input bit both, input string tag);
    @(negedge clk);
    wr_req    = 1'b1;
    rd_req    = both;
    addr      = a;
    wdata     = d;
    mem_ready = 1'b0;
    #1;
    chk(32'(data_ready), 0, {tag, " rdy0"});
    chk(32'(wr_done), 0, {tag, " done0"});
    for (int k = 1; k <= stall + 1; k++) begin
      @(negedge clk);
      mem_ready = (k == stall + 1);
      #1;
      chk(32'(mem_req), 1, {tag, " req"});
      chk(32'(mem_we), 1, {tag, " we"});
      chk(mem_addr, a, {tag, " addr"});
      chk(mem_wdata, d, {tag, " wdata"});
      chk(32'(data_ready), 0, {tag, " rdy"});
      chk(32'(wr_done), 32'(k == stall + 1), {tag, " done"});
      if (mem_ready && mem_req && mem_we) mem_m[mem_addr] = mem_wdata;
    end
    @(negedge clk);
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk(32'(wr_done), 0, {tag, " done after"});
    chk(32'(busy), 0, {tag, " busy after"});
    chk(32'(mem_req), 0, {tag, " req after"});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(32'(busy), 0, {tag, " busy"});
    chk(32'(mem_req), 0, {tag, " mem_req"});
    chk(32'(mem_we), 0, {tag, " mem_we"});
    chk(mem_addr, 0, {tag, " mem_addr"});
    chk(mem_wdata, 0, {tag, " mem_wdata"});
    chk(32'(wr_done), 0, {tag, " wr_done"});
    chk(32'(data_ready), 0, {tag, " data_ready"});
    chk(data_response, 0, {tag, " data_response"});
  endtask

  initial begin
    reset     = 1'b1;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    addr      = '0;
    wdata     = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    reset = 1'b0;

    rd(32'h100, 1, 5, "cold miss");
    rd(32'h10C, 1, 0, "line hit");
    wr(32'h108, 32'hDEADBEEF, 2, 1'b0, "store hit");
    rd(32'h108, 1, 0, "read after store");
    wr(32'h400, 32'h12345678, 0, 1'b0, "store miss");
    rd(32'h100, 1, 0, "no allocate");
    rd(32'h400, 1, 5, "read store miss");
    rd(32'h200, 1, 5, "conflict fill");
    rd(32'h100, 1, 5, "evicted reread");
    rd(32'h104, 1, 0, "refill hit");
    wr(32'h100, 32'hCAFE0001, 1, 1'b1, "rd wr both");
    rd(32'h100, 1, 0, "both result");
    rd(32'h344, 4, 17, "stall fill");
    rd(32'h348, 1, 0, "stall hit");

    // Abort a fill of 0x200 after two words have landed.
    @(negedge clk);
    rd_req    = 1'b1;
    addr      = 32'h200;
    mem_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = model(mem_addr);
    end
    @(negedge clk);
    reset  = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outs("mid fill reset");
    reset     = 1'b0;
    mem_ready = 1'b0;
    rd(32'h100, 1, 5, "miss after reset");
    rd(32'h200, 1, 5, "no partial line");

    @(negedge clk);
    rd_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
